bcd_7seg_scan: RTL and testbench
================================

Name: bcd_7seg_scan

Overview:
- Downstream consumer of the 8-bit binary-to-BCD converter: latches its HUNDREDS/TENS/ONES digits and drives a 3-digit multiplexed common-anode 7-segment display.
- Time-multiplexes the digits with a prescaled refresh counter, blanks leading zeros, suppresses ghosting with one blank cycle per digit switch, and flags BCD codes above 9.

Parameters:
- CLK_DIV, 50000, clocks per digit slot; legal range >= 2. Prescaler width is $clog2(CLK_DIV).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- load  in  1  strobe; capture ones/tens/hundreds on this edge
- ones  in  4  BCD units digit
- tens  in  4  BCD tens digit
- hundreds  in  4  BCD hundreds digit
- blank_lz  in  1  1 = enable leading-zero blanking; sampled live, not latched
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered
- an  out  3  anodes, active-low, registered; an[0]=ones, an[1]=tens, an[2]=hundreds
- frame  out  1  one-cycle pulse when the scan wraps from hundreds back to ones

Behaviour:
- Reset, on any rst=1 edge, including mid-scan:
  - Prescaler cnt=0, digit index idx=0, digit latches=0.
  - seg=7'h7F, an=3'b111, frame=0.
- Prescaler:
  - cnt counts 0..CLK_DIV-1; tick = (cnt==CLK_DIV-1).
  - On tick: cnt<=0 and idx advances 0->1->2->0.
  - Wrap-around is exact; idx never takes value 3.
- frame <= tick && idx==2, so frame is high for the cycle after the wrap edge.
- Output register update on each edge:
  - If tick: an<=3'b111, seg<=7'h7F. This is the ghost blank; exactly one cycle per slot.
  - Else: an<=~(3'b001<<idx), seg<=decode(sel), where sel is the latched digit for idx.
  - Net effect: each slot shows CLK_DIV-1 lit cycles and 1 dark cycle.
- First cycle after reset release: output edge drives an=3'b110 with the ones digit.
- Latch:
  - At an edge with load=1, all three digits are captured together; no partial capture.
  - The new value is displayed from the next output update, i.e. visible one cycle after the load edge in the currently lit slot.
  - load coincident with tick: the capture still occurs; the tick blank takes priority for that edge.
- Decode (active-low):
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
  - Codes 10..15 -> dash 7'h3F (segment g only).
- Leading-zero blanking, when blank_lz=1:
  - Hundreds slot: seg=7'h7F if latched hundreds==0.
  - Tens slot: seg=7'h7F if hundreds==0 and tens==0.
  - Ones slot is never blanked, so value 0 shows "0".
  - An invalid code is non-zero and therefore never blanked.
  - The anode still asserts for a blanked slot; only seg is forced off.
- blank_lz=0: all three digits are always shown.
- No input affects cnt/idx except rst. load does not restart the scan.

Decomposition:
- Shared package bcd_disp_pkg:
  - N_DIGITS=3.
  - SEG_OFF=7'h7F, SEG_DASH=7'h3F.
  - SEG_DIGIT[0:9] table above.
  - Typedef for 4-bit BCD digit and 7-bit segment vector.
- One combinational sub-module, bcd_to_seg: 4-bit BCD in, 7-bit active-low segments out, dash for >9. Instantiated once, fed by the idx-selected latched digit.

Test Plan (bench uses CLK_DIV=4):
- Reset mid-scan: assert rst while idx=2 -> next edge seg=7F, an=111, frame=0; after release, first edge an=110.
- load with h=1,t=2,o=3, blank_lz=0 -> slot ones: an=110 seg=30; tens: an=101 seg=24; hundreds: an=011 seg=79. Each slot is 3 lit cycles followed by 1 cycle an=111 seg=7F. frame pulses once per 12 cycles.
- Leading zeros: h=0,t=0,o=7, blank_lz=1 -> ones seg=78; tens and hundreds seg=7F with anodes 101/011 still asserted. Set blank_lz=0 -> tens and hundreds show 40.
- Inner zero: h=2,t=0,o=5, blank_lz=1 -> tens shows 40 (not blanked), hundreds 24, ones 12.
- Invalid BCD: o=4'hC, t=0, h=0, blank_lz=1 -> ones seg=3F; tens and hundreds blanked.
- load coincident with tick, values 9,9,9 -> the tick edge yields an=111, seg=7F; the following edge lights the next slot with seg=10. The prior value is never shown after the load edge.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared types and segment tables for the multiplexed BCD 7-segment display.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package bcd_disp_pkg;

   localparam int unsigned N_DIGITS = 3;
   localparam int unsigned BCD_W    = 4;
   localparam int unsigned SEG_W    = 7;

   typedef logic [BCD_W-1:0] bcd_t;
   typedef logic [SEG_W-1:0] seg_t;

   typedef struct packed {
      bcd_t hundreds;
      bcd_t tens;
      bcd_t ones;
   } bcd3_t;

   localparam seg_t SEG_OFF  = 7'h7F;
   localparam seg_t SEG_DASH = 7'h3F;

   localparam seg_t SEG_DIGIT [0:9] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 show a dash.
module bcd_to_seg
   import bcd_disp_pkg::*;
(
   input  logic [BCD_W-1:0] bcd_i,
   output logic [SEG_W-1:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      if (bcd_i <= BCD_W'(9)) begin
         seg_o = SEG_DIGIT[bcd_i];
      end
   end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Three-digit multiplexed common-anode display driver: latches BCD digits,
// scans them with a prescaled refresh, blanks leading zeros and ghosting.
module bcd_7seg_scan
   import bcd_disp_pkg::*;
#(
   parameter int unsigned CLK_DIV = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [BCD_W-1:0] ones,
   input  logic [BCD_W-1:0] tens,
   input  logic [BCD_W-1:0] hundreds,
   input  logic             blank_lz,
   output logic [SEG_W-1:0] seg,
   output logic [2:0]       an,
   output logic             frame
);

   localparam int unsigned CNT_W = $clog2(CLK_DIV);
   localparam int unsigned IDX_W = $clog2(N_DIGITS);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   bcd3_t            dig_q, dig_d;
   seg_t             seg_q, seg_d;
   logic [2:0]       an_q, an_d;
   logic             frame_q, frame_d;

   logic             tick_c;
   bcd_t             sel_c;
   seg_t             dec_c;
   logic             blank_c;

   assign tick_c = (cnt_q == CNT_MAX);

   // Select the digit for the current slot and decide leading-zero blanking.
   always_comb begin
      sel_c   = dig_q.ones;
      blank_c = 1'b0;
      case (idx_q)
         IDX_W'(0): begin
            sel_c   = dig_q.ones;
            blank_c = 1'b0;
         end
         IDX_W'(1): begin
            sel_c   = dig_q.tens;
            blank_c = blank_lz && (dig_q.hundreds == '0) && (dig_q.tens == '0);
         end
         default: begin
            sel_c   = dig_q.hundreds;
            blank_c = blank_lz && (dig_q.hundreds == '0);
         end
      endcase
   end

   bcd_to_seg u_dec (
      .bcd_i (sel_c),
      .seg_o (dec_c)
   );

   // Next-state: prescaler, slot index, digit latch and output register.
   always_comb begin
      cnt_d   = cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      dig_d   = dig_q;
      frame_d = tick_c && (idx_q == IDX_MAX);
      an_d    = ~(3'b001 << idx_q);
      seg_d   = blank_c ? SEG_OFF : dec_c;

      if (tick_c) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
         an_d  = 3'b111;
         seg_d = SEG_OFF;
      end

      if (load) begin
         dig_d.hundreds = hundreds;
         dig_d.tens     = tens;
         dig_d.ones     = ones;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         dig_q   <= '0;
         seg_q   <= SEG_OFF;
         an_q    <= 3'b111;
         frame_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         dig_q   <= dig_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         frame_q <= frame_d;
      end
   end

   assign seg   = seg_q;
   assign an    = an_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Directed bench for bcd_7seg_scan with a four-clock digit slot.
module tb_bcd_7seg_scan;

   localparam int CD  = 4;
   localparam int PER = 3 * CD;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic       blank_lz;
   logic [3:0] ones, tens, hundreds;
   logic [6:0] seg;
   logic [2:0] an;
   logic       frame;

   int total = 0;
   int bad   = 0;
   int k     = 0;

   typedef struct {
      logic [3:0] h, t, o;
      logic       blz;
      logic [6:0] eo, et, eh;
   } vec_t;

   vec_t vecs [8];

   always #5 clk = ~clk;

   bcd_7seg_scan #(.CLK_DIV(CD)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .ones     (ones),
      .tens     (tens),
      .hundreds (hundreds),
      .blank_lz (blank_lz),
      .seg      (seg),
      .an       (an),
      .frame    (frame)
   );

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic chk(input string name, input logic [2:0] ea,
                      input logic [6:0] es, input logic ef);
      total++;
      if (an !== ea || seg !== es || frame !== ef) begin
         bad++;
         $display("FAIL %s k=%0d got an=%b seg=%h frame=%b want an=%b seg=%h frame=%b",
                  name, k, an, seg, frame, ea, es, ef);
      end
   endtask

   // Expected outputs k edges after reset release, given per-slot segments.
   task automatic model(input int kk, input logic [6:0] eo, input logic [6:0] et,
                        input logic [6:0] eh, output logic [2:0] ea,
                        output logic [6:0] es, output logic ef);
      int ph, sl;
      ph = (kk - 1) % CD;
      sl = ((kk - 1) / CD) % 3;
      ef = ((kk % PER) == 0);
      if (ph == CD - 1) begin
         ea = 3'b111;
         es = 7'h7F;
      end else begin
         ea = 3'(~(3'b001 << sl));
         es = (sl == 0) ? eo : (sl == 1) ? et : eh;
      end
   endtask

   task automatic chk_model(input string name, input logic [6:0] eo,
                            input logic [6:0] et, input logic [6:0] eh);
      logic [2:0] ea;
      logic [6:0] es;
      logic       ef;
      model(k, eo, et, eh, ea, es, ef);
      chk(name, ea, es, ef);
   endtask

   // Reset, then load on the first edge after release; latches read back as zero.
   task automatic start_vec(input logic [3:0] h, input logic [3:0] t,
                            input logic [3:0] o, input logic blz);
      rst  = 1'b1;
      load = 1'b0;
      step();
      step();
      chk("reset", 3'b111, 7'h7F, 1'b0);
      rst      = 1'b0;
      k        = 0;
      load     = 1'b1;
      hundreds = h;
      tens     = t;
      ones     = o;
      blank_lz = blz;
      step();
      load = 1'b0;
      chk("first_edge", 3'b110, 7'h40, 1'b0);
   endtask

   initial begin
      rst      = 1'b1;
      load     = 1'b0;
      blank_lz = 1'b0;
      ones     = '0;
      tens     = '0;
      hundreds = '0;

      vecs[0] = '{h:4'd1, t:4'd2, o:4'd3, blz:1'b0, eo:7'h30, et:7'h24, eh:7'h79};
      vecs[1] = '{h:4'd0, t:4'd0, o:4'd7, blz:1'b1, eo:7'h78, et:7'h7F, eh:7'h7F};
      vecs[2] = '{h:4'd0, t:4'd0, o:4'd7, blz:1'b0, eo:7'h78, et:7'h40, eh:7'h40};
      vecs[3] = '{h:4'd2, t:4'd0, o:4'd5, blz:1'b1, eo:7'h12, et:7'h40, eh:7'h24};
      vecs[4] = '{h:4'd0, t:4'd0, o:4'hC, blz:1'b1, eo:7'h3F, et:7'h7F, eh:7'h7F};
      vecs[5] = '{h:4'd0, t:4'd0, o:4'd0, blz:1'b1, eo:7'h40, et:7'h7F, eh:7'h7F};
      vecs[6] = '{h:4'd8, t:4'd6, o:4'd4, blz:1'b1, eo:7'h19, et:7'h02, eh:7'h00};
      vecs[7] = '{h:4'd0, t:4'd9, o:4'hF, blz:1'b1, eo:7'h3F, et:7'h10, eh:7'h7F};

      // One full frame plus the next ones slot for every vector.
      foreach (vecs[i]) begin
         start_vec(vecs[i].h, vecs[i].t, vecs[i].o, vecs[i].blz);
         for (int e = 2; e <= PER + 2; e++) begin
            step();
            chk_model($sformatf("vec%0d", i), vecs[i].eo, vecs[i].et, vecs[i].eh);
         end
      end

      // Reset mid-scan just before the wrap edge that would raise frame.
      start_vec(4'd1, 4'd2, 4'd3, 1'b0);
      while (k < PER - 1) step();
      chk_model("pre_rst", 7'h30, 7'h24, 7'h79);
      rst = 1'b1;
      step();
      chk("rst_mid", 3'b111, 7'h7F, 1'b0);
      rst = 1'b0;
      k   = 0;
      step();
      chk("rst_release", 3'b110, 7'h40, 1'b0);
      step();
      chk("rst_latch_clr", 3'b110, 7'h40, 1'b0);

      // Load coincident with the ones-slot tick.
      start_vec(4'd1, 4'd2, 4'd3, 1'b0);
      step();
      step();
      chk("pre_tick", 3'b110, 7'h30, 1'b0);
      load     = 1'b1;
      hundreds = 4'd9;
      tens     = 4'd9;
      ones     = 4'd9;
      step();
      load = 1'b0;
      chk("load_tick", 3'b111, 7'h7F, 1'b0);
      step();
      chk("load_tick_next", 3'b101, 7'h10, 1'b0);
      while (k < PER + 2) begin
         step();
         chk_model("load_tick_run", 7'h10, 7'h10, 7'h10);
      end

      // Mid-slot load is visible one edge later.
      start_vec(4'd1, 4'd2, 4'd3, 1'b0);
      while (k < CD + 1) step();
      chk("mid_pre", 3'b101, 7'h24, 1'b0);
      load     = 1'b1;
      hundreds = 4'd4;
      tens     = 4'd5;
      ones     = 4'd6;
      step();
      load = 1'b0;
      chk("mid_load_edge", 3'b101, 7'h24, 1'b0);
      step();
      chk("mid_load_next", 3'b101, 7'h12, 1'b0);

      // blank_lz is sampled live.
      start_vec(4'd0, 4'd0, 4'd7, 1'b1);
      while (k < CD + 1) step();
      chk("blz_on", 3'b101, 7'h7F, 1'b0);
      blank_lz = 1'b0;
      step();
      chk("blz_off", 3'b101, 7'h40, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
